// File: rtl/odd_retire.sv
// odd_retire: odd-pipe retirement stage. Aligns permute and load/store
// writebacks by latency code and forwards every in-flight result.
module odd_retire #(
  parameter int STAGES = 7,
  parameter int PKT_W  = 139
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:PKT_W-1] perm_pkt,
  input  logic [0:PKT_W-1] ls_pkt,
  input  logic [0:6]       fwd_addr_a,
  input  logic [0:6]       fwd_addr_b,
  output logic             fwd_hit_a,
  output logic [0:127]     fwd_data_a,
  output logic             fwd_hit_b,
  output logic [0:127]     fwd_data_b,
  output logic             rf_we,
  output logic [0:6]       rf_addr,
  output logic [0:127]     rf_data,
  output logic             code_err,
  output logic [0:15]      retire_cnt
);

  localparam int FIRST = 4;
  localparam int DEPTH = STAGES - FIRST + 1;
  localparam int NSRC  = DEPTH + 1;
  localparam int VB    = 131;
  localparam logic [2:0] PERM_CODE = 3'd3;
  localparam logic [2:0] LS_CODE   = 3'd6;

  // stg[0] is stage 4, stg[DEPTH-1] is the final retire stage
  logic [0:PKT_W-1] stg [DEPTH];

  logic [2:0] perm_code;
  logic [2:0] ls_code;
  logic       perm_v;
  logic       perm_bad;
  logic       ls_v;
  logic       ls_ok;
  logic       ls_bad;
  logic       clash;

  assign perm_code = perm_pkt[128:130];
  assign ls_code   = ls_pkt[128:130];
  assign perm_v    = perm_pkt[VB];
  assign ls_v      = ls_pkt[VB];
  assign perm_bad  = perm_v && (perm_code != PERM_CODE);
  assign ls_ok     = ls_v && (ls_code == LS_CODE);
  assign ls_bad    = ls_v && (ls_code != LS_CODE);
  assign clash     = ls_ok && stg[DEPTH-2][VB];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
      code_err   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      stg[0] <= perm_bad ? '0 : perm_pkt;
      for (int i = 1; i < DEPTH - 1; i++) begin
        stg[i] <= stg[i-1];
      end
      stg[DEPTH-1] <= ls_ok ? ls_pkt : stg[DEPTH-2];
      rf_we      <= stg[DEPTH-1][VB];
      rf_addr    <= stg[DEPTH-1][132:138];
      rf_data    <= stg[DEPTH-1][0:127];
      retire_cnt <= retire_cnt + {15'd0, rf_we};
      if (perm_bad || ls_bad || clash) begin
        code_err <= 1'b1;
      end
    end
  end

  logic         src_v  [NSRC];
  logic [0:6]   src_rt [NSRC];
  logic [0:127] src_d  [NSRC];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_v[i]  = stg[i][VB];
      src_rt[i] = stg[i][132:138];
      src_d[i]  = stg[i][0:127];
    end
    src_v[DEPTH]  = rf_we;
    src_rt[DEPTH] = rf_addr;
    src_d[DEPTH]  = rf_data;
  end

  logic [1:0][0:6]   req;
  logic [1:0]        hit;
  logic [1:0][0:127] dat;

  assign req[0] = fwd_addr_a;
  assign req[1] = fwd_addr_b;

  // scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    hit = '0;
    dat = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (src_v[i] && (src_rt[i] == req[p])) begin
          hit[p] = 1'b1;
          dat[p] = src_d[i];
        end
      end
    end
  end

  assign fwd_hit_a  = hit[0];
  assign fwd_data_a = dat[0];
  assign fwd_hit_b  = hit[1];
  assign fwd_data_b = dat[1];

endmodule

// File: doc/odd_retire.md
# odd_retire

Odd-pipe retirement stage for the SPU-lite core. Sits directly downstream of the permute unit: it accepts the 139-bit writeback packets from permute and the load/store unit, aligns them by their latency code in a shift-register retirement pipe, and presents exactly one in-order register-file write per cycle. Every in-flight result is exposed to a two-port forwarding network so operand fetch never waits for a packet to reach the register file.

## Interface
Parameters
- `STAGES`, 7: index of the final retire stage; the internal pipe holds stages 4..`STAGES`.
- `PKT_W`, 139: packet width; bit ranges are defined in Operation.

Ports
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `perm_pkt`, in, [0:138]: permute writeback packet; expected latency code 3.
- `ls_pkt`, in, [0:138]: load/store writeback packet; expected latency code 6.
- `fwd_addr_a`, in, [0:6]: operand A register address.
- `fwd_addr_b`, in, [0:6]: operand B register address.
- `fwd_hit_a`, out, 1: A matches a valid in-flight result.
- `fwd_data_a`, out, [0:127]: forwarded A data; 0 when no hit.
- `fwd_hit_b`, out, 1: B matches a valid in-flight result.
- `fwd_data_b`, out, [0:127]: forwarded B data; 0 when no hit.
- `rf_we`, out, 1: register-file write enable.
- `rf_addr`, out, [0:6]: register-file write address.
- `rf_data`, out, [0:127]: register-file write data.
- `code_err`, out, 1: sticky flag for a latency-code mismatch.
- `retire_cnt`, out, [0:15]: count of retired writes; wraps.

## Operation
- Packet fields:
  - [0:127] data
  - [128:130] latency code
  - [131] write-enable/valid
  - [132:138] rt address
- A packet is valid only when bit 131 = 1. An all-zero packet is a bubble.
- Stage k (4..7) holds the instruction issued k cycles earlier. Each cycle, stage k+1 takes stage k, and stage 4 takes `perm_pkt`.
- Insertion points, applied after the shift:
  - `perm_pkt` enters stage 4 (code 3 + 1).
  - `ls_pkt` enters stage 7 (code 6 + 1), replacing the value shifted in from stage 6.
  - Shifting out of stage 6 into an ls-valid slot cannot occur by issue rules. If both are valid, `ls_pkt` wins and `code_err` sets.
- Code check:
  - A valid `perm_pkt` whose code is not 3 is dropped (stage 4 loads zero) and `code_err` sets.
  - A valid `ls_pkt` whose code is not 6 is dropped (the stage-7 shift-in value is kept) and `code_err` sets.
  - `code_err` clears only on reset.
- Retirement: `rf_we`/`rf_addr`/`rf_data` are registered copies of the stage-7 contents, i.e. bit 131, [132:138] and [0:127].
- `retire_cnt` increments on every cycle in which `rf_we` = 1, wrapping 0xFFFF → 0.
- Forwarding is combinational over stages 4..7 plus the registered retire output:
  - Priority is youngest first: stage 4 > 5 > 6 > 7 > retire register.
  - A stage matches when it is valid and its rt equals the requested address.
  - A miss drives data 0 and hit 0.
  - Ports A and B are fully independent and may hit the same stage.
- Register 0 is not special: it forwards and writes like any other register.

## Timing
- Reset (`reset` = 0 at a rising edge): all stages, retire outputs, `code_err` and `retire_cnt` go to 0, so every output reads 0 on the following cycle.
- A reset asserted mid-flight discards every in-flight packet; no write retires.
- Permute packet presented at cycle t:
  - in stage 4 at t+1, stage 7 at t+4;
  - `rf_we` high during cycle t+5;
  - forwardable from t+1 through t+5.
- LS packet presented at cycle t: in stage 7 at t+1, `rf_we` high at t+2.
- Forwarding has zero added latency: the outputs settle in the same cycle as `fwd_addr_*` and the stage contents.
- Throughput is one retire per cycle, with no backpressure and no stalls.

## Test plan
- Reset behaviour: hold `reset` = 0 for 2 cycles, then release.
  - All outputs must be 0.
  - Drive a valid perm packet (rt 5, data 0xA5…A5, code 3) at t0: `rf_we` = 1, `rf_addr` = 5, `rf_data` = 0xA5…A5 at t0+5, and `retire_cnt` = 1 afterward.
- Forwarding priority: perm rt 9 data 1 at t0 and perm rt 9 data 2 at t0+1.
  - With `fwd_addr_a` = 9 at t0+2: hit_a = 1, data_a = 2.
  - At t0+6: data_a = 2, coming from the retire register.
- Mixed insertion: perm rt 3 at t0, ls rt 4 at t0+3.
  - Retire order: rt 3 at t0+5, rt 4 at t0+5+… as per latency. Precisely: ls retires at t0+5 and perm at t0+5 would collide, so the bench must check that `code_err` = 1 and that rt 4 retires while rt 3 is lost.
  - Then repeat with ls at t0+4: rt 3 retires at t0+5 and rt 4 at t0+6, with `code_err` = 0.
- Bad code: perm packet with valid = 1 and code 5.
  - The packet never retires.
  - `code_err` = 1 from the next cycle and stays high until reset.
- Reset mid-flight: 4 perm packets issued back-to-back, then `reset` low for 1 cycle after the 2nd.
  - Only packets presented after reset retires.
  - `retire_cnt` counts only those.
- Counter wrap: preload via 65536 retires.
  - `retire_cnt` returns to 0.
  - Forward misses on unused addresses return hit 0, data 0.
